// File: rtl/transmisor_pin.sv
// transmisor_pin: card/keypad front end for the automatic cashier.
// Detects card insertion, captures N_DIGITS keypad digits into a local
// buffer, streams them to the cashier over a valid/ready handshake and
// holds the session until the cashier raises fin.
// Optional build macro: PIN_BORRAR_EN enables the editing keys
// (4'hA = backspace, 4'hB = clear entry) during capture.
module transmisor_pin #(
  parameter int N_DIGITS = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tarjeta_insertada,
  input  logic       tecla_valida,
  input  logic [3:0] tecla,
  input  logic       digito_listo,
  input  logic       fin,
  output logic       tarjeta_recibida,
  output logic [3:0] digito,
  output logic       digito_valido,
  output logic       pin_enviado,
  output logic       error_tecla,
  output logic       abortado
);

  localparam int CNT_W = $clog2(N_DIGITS + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int BUF_W = 4 * N_DIGITS;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_ZERO = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};
  localparam logic [BUF_W-1:0] BUF_ZERO = {BUF_W{1'b0}};

  // One-hot session states; the spare code is illegal and recovers to idle.
  typedef enum logic [4:0] {
    ST_IDLE       = 5'b00001,
    ST_CAPTURA    = 5'b00010,
    ST_ENVIO      = 5'b00100,
    ST_ESPERA_FIN = 5'b01000,
    ST_SPARE      = 5'b10000
  } state_t;

  state_t           state_q, state_d;
  logic [BUF_W-1:0] buffer_q, buffer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tarjeta_recibida_q, tarjeta_recibida_d;
  logic [3:0]       digito_q, digito_d;
  logic             digito_valido_q, digito_valido_d;
  logic             pin_enviado_q, pin_enviado_d;
  logic             error_tecla_q, error_tecla_d;
  logic             abortado_q, abortado_d;

  logic             key_digit;
  logic             tmo_clear;
  logic [TMO_W-1:0] tmo_inc;

  // Read the 4-bit slot idx out of the digit buffer.
  function automatic logic [3:0] digit_at(input logic [BUF_W-1:0] buf_v,
                                          input logic [CNT_W-1:0] idx);
    logic [3:0] d;
    d = 4'h0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == CNT_W'(k)) begin
        d = buf_v[k*4 +: 4];
      end
    end
    return d;
  endfunction

  // Return a copy of the buffer with slot idx replaced by val.
  function automatic logic [BUF_W-1:0] digit_set(input logic [BUF_W-1:0] buf_v,
                                                 input logic [CNT_W-1:0] idx,
                                                 input logic [3:0]       val);
    logic [BUF_W-1:0] r;
    r = buf_v;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == CNT_W'(k)) begin
        r[k*4 +: 4] = val;
      end
    end
    return r;
  endfunction

  // Key classification and saturating inter-key idle counter increment.
  always_comb begin
    key_digit = (tecla <= 4'd9);
    if (tmo_q == TMO_MAX) begin
      tmo_inc = tmo_q;
    end else begin
      tmo_inc = tmo_q + TMO_W'(1);
    end
  end

  // Next-state and next-output logic for the session FSM and datapath.
  always_comb begin
    state_d            = state_q;
    buffer_d           = buffer_q;
    count_d            = count_q;
    idx_d              = idx_q;
    tmo_d              = tmo_q;
    digito_d           = 4'h0;
    digito_valido_d    = 1'b0;
    pin_enviado_d      = 1'b0;
    error_tecla_d      = 1'b0;
    abortado_d         = 1'b0;
    tmo_clear          = 1'b0;
    tarjeta_recibida_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        buffer_d = BUF_ZERO;
        count_d  = CNT_ZERO;
        idx_d    = CNT_ZERO;
        tmo_d    = TMO_ZERO;
        if (tarjeta_insertada) begin
          state_d = ST_CAPTURA;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CAPTURA: begin
        if (!tarjeta_insertada) begin
          // Card pulled: dominates any key or timeout in the same cycle.
          state_d    = ST_IDLE;
          abortado_d = 1'b1;
          buffer_d   = BUF_ZERO;
          count_d    = CNT_ZERO;
          tmo_d      = TMO_ZERO;
        end else if (count_q == CNT_FULL) begin
          // Entry complete: further keys are ignored, start offering digit 0.
          state_d         = ST_ENVIO;
          idx_d           = CNT_ZERO;
          tmo_d           = TMO_ZERO;
          digito_valido_d = 1'b1;
          digito_d        = digit_at(buffer_q, CNT_ZERO);
        end else begin
          if (tecla_valida && key_digit) begin
            buffer_d  = digit_set(buffer_q, count_q, tecla);
            count_d   = count_q + CNT_ONE;
            tmo_clear = 1'b1;
`ifdef PIN_BORRAR_EN
          end else if (tecla_valida && (tecla == 4'hA)) begin
            // Backspace; on an empty entry it has no effect at all.
            if (count_q != CNT_ZERO) begin
              count_d   = count_q - CNT_ONE;
              buffer_d  = digit_set(buffer_q, count_q - CNT_ONE, 4'h0);
              tmo_clear = 1'b1;
            end else begin
              tmo_clear = 1'b0;
            end
          end else if (tecla_valida && (tecla == 4'hB)) begin
            count_d  = CNT_ZERO;
            buffer_d = BUF_ZERO;
`endif
          end else if (tecla_valida) begin
            error_tecla_d = 1'b1;
          end else begin
            error_tecla_d = 1'b0;
          end

          if (tmo_clear) begin
            tmo_d = TMO_ZERO;
          end else if (tmo_inc == TMO_LIM) begin
            // Too long without an accepted digit: drop the session.
            state_d       = ST_IDLE;
            abortado_d    = 1'b1;
            error_tecla_d = 1'b0;
            buffer_d      = BUF_ZERO;
            count_d       = CNT_ZERO;
            tmo_d         = TMO_ZERO;
          end else begin
            tmo_d = tmo_inc;
          end
        end
      end

      ST_ENVIO: begin
        if (!tarjeta_insertada) begin
          // Card pulled: dominates a transfer in the same cycle.
          state_d    = ST_IDLE;
          abortado_d = 1'b1;
          buffer_d   = BUF_ZERO;
          count_d    = CNT_ZERO;
          idx_d      = CNT_ZERO;
        end else if (digito_valido_q && digito_listo) begin
          if (idx_q == CNT_LAST) begin
            state_d       = ST_ESPERA_FIN;
            pin_enviado_d = 1'b1;
          end else begin
            idx_d           = idx_q + CNT_ONE;
            digito_valido_d = 1'b1;
            digito_d        = digit_at(buffer_q, idx_q + CNT_ONE);
          end
        end else begin
          // Receiver not ready: hold the offered digit.
          digito_valido_d = 1'b1;
          digito_d        = digit_at(buffer_q, idx_q);
        end
      end

      ST_ESPERA_FIN: begin
        // Only fin ends the session here; card removal is ignored.
        if (fin) begin
          state_d  = ST_IDLE;
          buffer_d = BUF_ZERO;
          count_d  = CNT_ZERO;
          idx_d    = CNT_ZERO;
        end else begin
          state_d = ST_ESPERA_FIN;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        buffer_d = BUF_ZERO;
        count_d  = CNT_ZERO;
        idx_d    = CNT_ZERO;
        tmo_d    = TMO_ZERO;
      end
    endcase

    tarjeta_recibida_d = (state_d == ST_CAPTURA) || (state_d == ST_ENVIO) ||
                         (state_d == ST_ESPERA_FIN);
  end

  // State, datapath and registered outputs with asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= ST_IDLE;
      buffer_q           <= BUF_ZERO;
      count_q            <= CNT_ZERO;
      idx_q              <= CNT_ZERO;
      tmo_q              <= TMO_ZERO;
      tarjeta_recibida_q <= 1'b0;
      digito_q           <= 4'h0;
      digito_valido_q    <= 1'b0;
      pin_enviado_q      <= 1'b0;
      error_tecla_q      <= 1'b0;
      abortado_q         <= 1'b0;
    end else begin
      state_q            <= state_d;
      buffer_q           <= buffer_d;
      count_q            <= count_d;
      idx_q              <= idx_d;
      tmo_q              <= tmo_d;
      tarjeta_recibida_q <= tarjeta_recibida_d;
      digito_q           <= digito_d;
      digito_valido_q    <= digito_valido_d;
      pin_enviado_q      <= pin_enviado_d;
      error_tecla_q      <= error_tecla_d;
      abortado_q         <= abortado_d;
    end
  end

  assign tarjeta_recibida = tarjeta_recibida_q;
  assign digito           = digito_q;
  assign digito_valido    = digito_valido_q;
  assign pin_enviado      = pin_enviado_q;
  assign error_tecla      = error_tecla_q;
  assign abortado         = abortado_q;

endmodule

// File: tb/tb_transmisor_pin.sv
// Self-checking bench for transmisor_pin: a cycle table for the basic
// sessions, hand-written corner sequences and randomized sessions scored
// against a key-list model of the expected PIN and error count.
module tb_transmisor_pin;
  localparam int N_DIG = 4;
  localparam int TMO   = 255;

  logic       clk;
  logic       reset;
  logic       tarjeta_insertada;
  logic       tecla_valida;
  logic [3:0] tecla;
  logic       digito_listo;
  logic       fin;
  logic       tarjeta_recibida;
  logic [3:0] digito;
  logic       digito_valido;
  logic       pin_enviado;
  logic       error_tecla;
  logic       abortado;
  logic [8:0] outs;

  transmisor_pin #(.N_DIGITS(N_DIG), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .tarjeta_insertada(tarjeta_insertada),
    .tecla_valida(tecla_valida), .tecla(tecla), .digito_listo(digito_listo),
    .fin(fin), .tarjeta_recibida(tarjeta_recibida), .digito(digito),
    .digito_valido(digito_valido), .pin_enviado(pin_enviado),
    .error_tecla(error_tecla), .abortado(abortado)
  );

  assign outs = {tarjeta_recibida, digito_valido, digito, pin_enviado, error_tecla, abortado};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_err, n_pin, n_ab;

  logic [3:0] keys_q[$];
  logic [3:0] exp_pin[$];
  int         exp_err;
  logic [3:0] got[$];

  typedef struct {
    logic       card;
    logic       kv;
    logic [3:0] key;
    logic       listo;
    logic       fin;
    logic [8:0] exp;
  } vec_t;

  vec_t vt[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (error_tecla === 1'b1) n_err++;
    if (pin_enviado === 1'b1) n_pin++;
    if (abortado === 1'b1) n_ab++;
  endtask

  function automatic vec_t mk(input logic card, input logic kv, input logic [3:0] key,
                              input logic listo, input logic f, input logic [8:0] exp);
    vec_t v;
    v.card = card; v.kv = kv; v.key = key; v.listo = listo; v.fin = f; v.exp = exp;
    return v;
  endfunction

  // Reference: replay the key list, the first N_DIG surviving digits are the PIN.
  function automatic void model_keys();
    exp_pin.delete();
    exp_err = 0;
    foreach (keys_q[i]) begin
      if (exp_pin.size() < N_DIG) begin
        if (keys_q[i] <= 4'd9) exp_pin.push_back(keys_q[i]);
`ifdef PIN_BORRAR_EN
        else if (keys_q[i] == 4'hA) begin
          if (exp_pin.size() > 0) void'(exp_pin.pop_back());
        end
        else if (keys_q[i] == 4'hB) exp_pin.delete();
`endif
        else exp_err++;
      end
    end
  endfunction

  task automatic gen_keys();
    keys_q.delete();
    for (int i = 0; i < 64; i++) begin
      model_keys();
      if (exp_pin.size() >= N_DIG) break;
      if (i < 12 && $urandom_range(0, 4) == 0) keys_q.push_back(4'($urandom_range(10, 15)));
      else keys_q.push_back(4'($urandom_range(0, 9)));
    end
  endtask

  // Full session: insert card, type keys_q, drain PIN (mode 0 random ready,
  // 1 fixed ready pattern 1,0,0,1,1,0,1, 2 always ready), then fin.
  task automatic run_session(input string tag, input int mode);
    logic [6:0] pat;
    logic [3:0] prev_dig;
    logic       prev_hold;
    logic       listo;
    int         bad;
    int         cyc;
    int         waited;
    pat = 7'b1011001;
    model_keys();
    n_err = 0; n_pin = 0; n_ab = 0; bad = 0;
    got.delete();
    tarjeta_insertada = 1'b1; fin = 1'b0; digito_listo = 1'b0; tecla_valida = 1'b0;
    tick();
    check({tag, "_tr"}, {31'd0, tarjeta_recibida}, 32'd1);
    foreach (keys_q[i]) begin
      repeat ($urandom_range(0, 3)) tick();
      tecla_valida = 1'b1; tecla = keys_q[i];
      tick();
      tecla_valida = 1'b0; tecla = 4'h0;
    end
    waited = 0;
    while (digito_valido !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    check({tag, "_envio_start"}, {31'd0, digito_valido}, 32'd1);
    cyc = 0; prev_hold = 1'b0; prev_dig = 4'h0;
    while (n_pin == 0 && cyc < 200) begin
      if (digito_valido !== 1'b1 && digito !== 4'h0) bad++;
      if (prev_hold && (digito_valido !== 1'b1 || digito !== prev_dig)) bad++;
      if (mode == 0) listo = 1'($urandom_range(0, 1));
      else if (mode == 1) listo = (cyc < 7) ? pat[cyc] : 1'b1;
      else listo = 1'b1;
      digito_listo = listo;
      if (digito_valido === 1'b1 && listo) got.push_back(digito);
      prev_hold = (digito_valido === 1'b1) && !listo;
      prev_dig = digito;
      tick();
      cyc++;
    end
    digito_listo = 1'b0;
    check({tag, "_pin_pulses"}, n_pin, 32'd1);
    check({tag, "_dv_after"}, {27'd0, digito_valido, digito}, 32'd0);
    check({tag, "_n_xfer"}, got.size(), exp_pin.size());
    for (int i = 0; i < exp_pin.size() && i < got.size(); i++)
      check($sformatf("%s_digit%0d", tag, i), {28'd0, got[i]}, {28'd0, exp_pin[i]});
    check({tag, "_errors"}, n_err, exp_err);
    check({tag, "_hold"}, bad, 32'd0);
    check({tag, "_no_abort"}, n_ab, 32'd0);
    tarjeta_insertada = 1'b0; fin = 1'b1;
    tick();
    check({tag, "_fin_tr"}, {31'd0, tarjeta_recibida}, 32'd0);
    fin = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; tarjeta_insertada = 1'b0; tecla_valida = 1'b0; tecla = 4'h0;
    digito_listo = 1'b0; fin = 1'b0;
    n_err = 0; n_pin = 0; n_ab = 0;

    vt[0]  = mk(1, 0, 4'h0, 0, 0, 9'h100);
    vt[1]  = mk(1, 1, 4'h1, 0, 0, 9'h100);
    vt[2]  = mk(1, 1, 4'h2, 0, 0, 9'h100);
    vt[3]  = mk(1, 1, 4'h3, 0, 0, 9'h100);
    vt[4]  = mk(1, 1, 4'h4, 0, 0, 9'h100);
    vt[5]  = mk(1, 0, 4'h0, 1, 0, 9'h188);
    vt[6]  = mk(1, 0, 4'h0, 1, 0, 9'h190);
    vt[7]  = mk(1, 0, 4'h0, 1, 0, 9'h198);
    vt[8]  = mk(1, 0, 4'h0, 1, 0, 9'h1A0);
    vt[9]  = mk(1, 0, 4'h0, 1, 0, 9'h104);
    vt[10] = mk(0, 0, 4'h0, 0, 0, 9'h100);
    vt[11] = mk(0, 0, 4'h0, 0, 1, 9'h000);
    vt[12] = mk(0, 0, 4'h0, 0, 0, 9'h000);
    vt[13] = mk(1, 0, 4'h0, 0, 0, 9'h100);
    vt[14] = mk(1, 1, 4'h5, 0, 0, 9'h100);
    vt[15] = mk(1, 1, 4'hC, 0, 0, 9'h102);
    vt[16] = mk(1, 1, 4'h7, 0, 0, 9'h100);
    vt[17] = mk(1, 1, 4'h8, 0, 0, 9'h100);
    vt[18] = mk(1, 1, 4'h9, 0, 0, 9'h100);
    vt[19] = mk(1, 0, 4'h0, 1, 0, 9'h1A8);
    vt[20] = mk(1, 0, 4'h0, 1, 0, 9'h1B8);
    vt[21] = mk(1, 0, 4'h0, 1, 0, 9'h1C0);
    vt[22] = mk(1, 0, 4'h0, 1, 0, 9'h1C8);
    vt[23] = mk(1, 0, 4'h0, 1, 0, 9'h104);
    vt[24] = mk(0, 0, 4'h0, 0, 1, 9'h000);

    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {23'd0, outs}, 32'd0);
    reset = 1'b1;
    tick();
    check("idle_outs", {23'd0, outs}, 32'd0);

    // Cycle table: happy path 1,2,3,4 then 5,C,7,8,9.
    for (int i = 0; i < 25; i++) begin
      tarjeta_insertada = vt[i].card; tecla_valida = vt[i].kv; tecla = vt[i].key;
      digito_listo = vt[i].listo; fin = vt[i].fin;
      tick();
      check($sformatf("vec%0d", i), {23'd0, outs}, {23'd0, vt[i].exp});
    end
    tecla_valida = 1'b0; tecla = 4'h0; digito_listo = 1'b0; fin = 1'b0; tarjeta_insertada = 1'b0;
    tick();

    // Ready toggling 1,0,0,1,1,0,1.
    keys_q = '{4'h3, 4'h1, 4'h4, 4'h1};
    run_session("pat", 1);

    // Timeout after one digit, then a clean new session.
    tarjeta_insertada = 1'b1;
    tick();
    tecla_valida = 1'b1; tecla = 4'h3;
    tick();
    tecla_valida = 1'b0; tecla = 4'h0;
    repeat (254) tick();
    check("tmo_before", {30'd0, abortado, tarjeta_recibida}, 32'd1);
    tick();
    check("tmo_pulse", {31'd0, abortado}, 32'd1);
    check("tmo_tr", {31'd0, tarjeta_recibida}, 32'd0);
    tick();
    check("tmo_recapture", {30'd0, abortado, tarjeta_recibida}, 32'd1);
    keys_q = '{4'h6, 4'h7, 4'h8, 4'h9};
    run_session("after_tmo", 2);

    // Card pulled after two digits, together with a bad key.
    tarjeta_insertada = 1'b1;
    tick();
    tecla_valida = 1'b1; tecla = 4'h1; tick();
    tecla = 4'h2; tick();
    tarjeta_insertada = 1'b0; tecla = 4'hE; tick();
    check("pull_outs", {23'd0, outs}, 32'h001);
    tecla_valida = 1'b0; tecla = 4'h0; tick();
    check("pull_once", {23'd0, outs}, 32'h000);
    keys_q = '{4'h9, 4'h8, 4'h7, 4'h6};
    run_session("after_pull", 0);

    // Card pulled in ENVIO while the receiver is ready.
    tarjeta_insertada = 1'b1; tick();
    for (int i = 1; i <= 4; i++) begin
      tecla_valida = 1'b1; tecla = 4'(i); tick();
    end
    tecla_valida = 1'b0; tecla = 4'h0; tick();
    check("envio_first", {23'd0, outs}, 32'h188);
    digito_listo = 1'b1; tarjeta_insertada = 1'b0; tick();
    check("envio_pull", {23'd0, outs}, 32'h001);
    digito_listo = 1'b0; tick();
    check("envio_pull_after", {23'd0, outs}, 32'h000);

    // Asynchronous reset in the middle of ENVIO.
    tarjeta_insertada = 1'b1; tick();
    for (int i = 5; i <= 8; i++) begin
      tecla_valida = 1'b1; tecla = 4'(i); tick();
    end
    tecla_valida = 1'b0; tecla = 4'h0; tick();
    digito_listo = 1'b1; tick();
    check("pre_reset", {23'd0, outs}, 32'h1B0);
    digito_listo = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("async_reset", {23'd0, outs}, 32'h000);
    tarjeta_insertada = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    check("post_reset_idle", {23'd0, outs}, 32'h000);
    gen_keys();
    run_session("after_reset", 2);

    // Editing keys (accepted as edits only when PIN_BORRAR_EN is built in).
    keys_q = '{4'h1, 4'h2, 4'hA, 4'h9, 4'hB, 4'h4, 4'h4, 4'h4, 4'h4};
    run_session("borrar", 2);

    // Randomized sessions.
    for (int s = 0; s < 8; s++) begin
      gen_keys();
      run_session($sformatf("rnd%0d", s), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/transmisor_pin.md
Name: transmisor_pin

Overview:
Card/keypad-side front end that drives the automatic cashier's card-and-PIN interface. It detects card insertion and raises tarjeta_recibida toward the cashier FSM. It captures N_DIGITS keypad digits into a local buffer, then streams them one per handshake to the cashier's PIN receiver. It holds the session until the cashier signals fin.

Parameters:
N_DIGITS, 4, number of PIN digits captured and transmitted (1..8)
TIMEOUT, 255, max cycles between accepted keys in CAPTURE before abort (1..65535)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
tarjeta_insertada  input  1  card sensor level, high while card present
tecla_valida  input  1  one-cycle strobe: tecla holds a new keypress
tecla  input  4  key code; 0-9 = digits, A-F = non-digit keys
digito_listo  input  1  cashier ready to accept a digit
fin  input  1  cashier transaction finished (level or pulse)
tarjeta_recibida  output  1  session active, to cashier
digito  output  4  PIN digit being offered
digito_valido  output  1  digito is valid (valid/ready handshake)
pin_enviado  output  1  one-cycle pulse after the last digit transfers
error_tecla  output  1  one-cycle pulse on a rejected key
abortado  output  1  one-cycle pulse on timeout abort

Behaviour:
- One-hot state register, 5 bits: IDLE=00001, CAPTURA=00010, ENVIO=00100, ESPERA_FIN=01000, spare 10000 (illegal; goes to IDLE).
- Reset (reset=0, async): state IDLE; all outputs 0; digit count, send index, timeout counter and buffer cleared.
- IDLE: all outputs 0. tarjeta_insertada=1 -> CAPTURA next cycle. Counters cleared on entry.
- tarjeta_recibida is registered. It is 1 in CAPTURA, ENVIO and ESPERA_FIN, and 0 otherwise.
- CAPTURA:
  - tecla_valida=1 with tecla<=9: tecla is stored in buffer[count], count increments, timeout counter clears.
  - tecla_valida=1 with tecla>9: key is not stored; error_tecla pulses on the next cycle.
  - When count reaches N_DIGITS, the state goes to ENVIO on the following cycle. Further keys are ignored and raise no error.
  - Timeout counter increments on every cycle without an accepted digit. At TIMEOUT: go to IDLE, abortado pulses for 1 cycle, buffer is cleared.
  - tarjeta_insertada=0 (card pulled) in CAPTURA or ENVIO: go to IDLE next cycle, abortado pulses, buffer is cleared.
- ENVIO:
  - digito_valido=1 and digito=buffer[idx].
  - A transfer occurs on any cycle where digito_valido=1 and digito_listo=1. On a transfer, idx increments and digito updates in the same edge.
  - digito is held stable while digito_listo=0. No timeout applies in ENVIO.
  - On transfer of idx=N_DIGITS-1: digito_valido drops the next cycle, pin_enviado pulses 1 cycle, state goes to ESPERA_FIN.
  - Throughput: 1 digit/cycle when digito_listo is held high. N_DIGITS=4 completes in 4 cycles.
- ESPERA_FIN: digito_valido=0. fin=1 -> IDLE next cycle, buffer cleared, tarjeta_recibida drops. Card removal here is ignored; only fin exits.
- Simultaneous events:
  - Card removal takes priority over a key strobe or the timeout in the same cycle. Only one abortado pulse is generated.
  - In ENVIO, card removal takes priority over a transfer.
- Output rule: digito=0 whenever digito_valido=0.
- Buffer is 4*N_DIGITS bits. Count and idx are clog2(N_DIGITS+1) bits. Timeout counter is clog2(TIMEOUT+1) bits and saturates.

Optional Feature:
PIN_BORRAR_EN
- Defined:
  - In CAPTURA, tecla=4'hA is backspace: count decrements if count>0 and the timeout counter clears. With count=0 it is ignored, no error.
  - tecla=4'hB clears the whole entry: count=0, buffer cleared.
  - Neither key raises error_tecla. Other codes >9 still raise error_tecla.
- Undefined: every code >9 is rejected with error_tecla.

Test Plan:
- Reset, insert card, keys 1,2,3,4, digito_listo=1 -> tarjeta_recibida=1; digito sequence 1,2,3,4 on 4 consecutive cycles; pin_enviado pulses once; fin=1 -> IDLE, tarjeta_recibida=0.
- Keys 5,C,7,8,9 -> error_tecla pulses once for C; transmitted PIN is 5,7,8,9.
- ENVIO with digito_listo toggling 1,0,0,1,1,0,1 -> each digit held stable while not ready; exactly 4 transfers, order preserved.
- Key 3, then no keys for 255 cycles -> abortado pulses; state IDLE; tarjeta_recibida=0; next session starts with count=0.
- Card pulled after 2 digits, and reset asserted mid-ENVIO -> IDLE; all outputs 0 asynchronously on reset.
- PIN_BORRAR_EN: keys 1,2,A,9,B,4,4,4,4 -> transmitted PIN 4,4,4,4; no error_tecla.
